// File: rtl/fp16mul_arbiter_pkg.sv
// fp16mul_arbiter_pkg: FP16 format constants shared by the multiplier and
// the arbiter top.
//   FP16_WIDTH  - total bits in an FP16 word
//   FP16_EXP_W  - exponent field width
//   FP16_MAN_W  - stored mantissa width
//   FP16_BIAS   - exponent bias
//   FP16_EXP_MAX- all-ones exponent (inf / NaN)
//   FP16_QNAN   - canonical NaN encoding produced by fp16mul
package fp16mul_arbiter_pkg;
  localparam int FP16_WIDTH = 16;
  localparam int FP16_EXP_W = 5;
  localparam int FP16_MAN_W = 10;
  localparam int FP16_BIAS  = 15;
  localparam logic [FP16_EXP_W-1:0] FP16_EXP_MAX = '1;
  localparam logic [FP16_WIDTH-1:0] FP16_QNAN    = 16'h7E00;
endpackage

// File: rtl/fp16mul.sv
// fp16mul: combinational FP16 multiplier.
//   i_a, i_b : FP16 operands
//   o_p      : FP16 product
// Subnormal inputs are treated as zero, subnormal results flush to signed
// zero, mantissa is truncated (round toward zero). Exponent overflow
// saturates to signed infinity. Any NaN input or inf*0 gives FP16_QNAN.
module fp16mul
  import fp16mul_arbiter_pkg::*;
(
  input  logic [FP16_WIDTH-1:0] i_a,
  input  logic [FP16_WIDTH-1:0] i_b,
  output logic [FP16_WIDTH-1:0] o_p
);
  logic                  sign;
  logic [FP16_EXP_W-1:0] ea, eb;
  logic [FP16_MAN_W-1:0] fa, fb, mant;
  logic                  a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [21:0]           prod;
  logic [7:0]            esum;
  logic                  unused_bits;

  assign ea = i_a[14:10];
  assign eb = i_b[14:10];
  assign fa = i_a[9:0];
  assign fb = i_b[9:0];
  assign sign = i_a[15] ^ i_b[15];

  assign a_nan  = (ea == FP16_EXP_MAX) && (fa != '0);
  assign b_nan  = (eb == FP16_EXP_MAX) && (fb != '0);
  assign a_inf  = (ea == FP16_EXP_MAX) && (fa == '0);
  assign b_inf  = (eb == FP16_EXP_MAX) && (fb == '0);
  assign a_zero = (ea == '0);  // zero exponent covers subnormals (DAZ)
  assign b_zero = (eb == '0);

  assign prod = {1'b1, fa} * {1'b1, fb};
  // Biased exponent sum kept unbiased-plus-15 so all comparisons stay unsigned.
  assign esum = {3'b0, ea} + {3'b0, eb} + {7'b0, prod[21]};
  assign mant = prod[21] ? prod[20:11] : prod[19:10];
  assign unused_bits = ^prod[9:0];

  always_comb begin
    o_p = {sign, 5'(esum - 8'(FP16_BIAS)), mant};
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
      o_p = FP16_QNAN;
    else if (a_inf || b_inf)
      o_p = {sign, FP16_EXP_MAX, 10'h0};
    else if (a_zero || b_zero)
      o_p = {sign, 15'h0};
    else if (esum >= 8'(FP16_BIAS + 31))
      o_p = {sign, FP16_EXP_MAX, 10'h0};
    else if (esum <= 8'(FP16_BIAS))
      o_p = {sign, 15'h0};
  end
endmodule

// File: rtl/fp16mul_arbiter_rr.sv
// rr_arbiter: round-robin grant with a registered priority pointer.
//   i_clk, i_rst : clock, synchronous active-high reset (ptr -> 0)
//   i_req        : request vector
//   i_en         : grant enable; no grant and no pointer move when low
//   o_grant      : one-hot grant (zero when disabled or no request)
//   o_grant_id   : index of the selected requester
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N-1:0]    i_req,
  input  logic            i_en,
  output logic [N-1:0]    o_grant,
  output logic [ID_W-1:0] o_grant_id
);
  logic [ID_W-1:0] ptr;
  logic            found;
  int              idx;

  // Scan upward from ptr, wrapping at N-1; first hit wins.
  always_comb begin
    o_grant    = '0;
    o_grant_id = '0;
    found      = 1'b0;
    idx        = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && i_req[idx]) begin
        found      = 1'b1;
        o_grant_id = ID_W'(idx);
      end
    end
    if (i_en && found) o_grant[o_grant_id] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      ptr <= '0;
    else if (|o_grant)
      ptr <= (o_grant_id == ID_W'(N-1)) ? '0 : o_grant_id + 1'b1;
  end
endmodule

// File: rtl/fp16mul_arbiter.sv
// fp16mul_arbiter: shares one combinational fp16mul among NREQ requesters.
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_req_valid   : per-requester valid
//   i_req_a/b     : operands, requester k in bits [16k+15:16k]
//   o_req_ready   : one-hot accept
//   o_res_valid   : result register occupied
//   o_res         : registered product
//   o_res_id      : requester that owns o_res
//   i_res_ready   : consumer takes the result
//   o_busy        : result pending or any request outstanding
module fp16mul_arbiter
  import fp16mul_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NREQ-1:0]            i_req_valid,
  input  logic [NREQ*FP16_WIDTH-1:0] i_req_a,
  input  logic [NREQ*FP16_WIDTH-1:0] i_req_b,
  output logic [NREQ-1:0]            o_req_ready,
  output logic                       o_res_valid,
  output logic [FP16_WIDTH-1:0]      o_res,
  output logic [ID_W-1:0]            o_res_id,
  input  logic                       i_res_ready,
  output logic                       o_busy
);
  logic                  slot_free;
  logic                  grant_en;
  logic [ID_W-1:0]       grant_id;
  logic [FP16_WIDTH-1:0] op_a, op_b, prod;

  // Single-entry output register that can drain and refill in the same cycle.
  assign slot_free = !o_res_valid || i_res_ready;
  assign grant_en  = slot_free && !i_rst;

  rr_arbiter #(.N(NREQ), .ID_W(ID_W)) u_arb (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_req      (i_req_valid),
    .i_en       (grant_en),
    .o_grant    (o_req_ready),
    .o_grant_id (grant_id)
  );

  // One-hot AND-OR operand mux; zero operands when nothing is granted.
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      op_a |= i_req_a[k*FP16_WIDTH +: FP16_WIDTH] & {FP16_WIDTH{o_req_ready[k]}};
      op_b |= i_req_b[k*FP16_WIDTH +: FP16_WIDTH] & {FP16_WIDTH{o_req_ready[k]}};
    end
  end

  fp16mul u_mul (
    .i_a (op_a),
    .i_b (op_b),
    .o_p (prod)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_res_valid <= 1'b0;
      o_res       <= '0;
      o_res_id    <= '0;
    end else if (|o_req_ready) begin
      o_res_valid <= 1'b1;
      o_res       <= prod;
      o_res_id    <= grant_id;
    end else if (i_res_ready) begin
      o_res_valid <= 1'b0;
    end
  end

  assign o_busy = o_res_valid || (|i_req_valid);
endmodule

// File: tb/tb_fp16mul_arbiter.sv
module tb_fp16mul_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_a, req_b;
  logic [3:0]  req_ready;
  logic        res_valid;
  logic [15:0] res;
  logic [1:0]  res_id;
  logic        res_ready;
  logic        busy;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  fp16mul_arbiter #(.NREQ(4), .ID_W(2)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .i_req_a     (req_a),
    .i_req_b     (req_b),
    .o_req_ready (req_ready),
    .o_res_valid (res_valid),
    .o_res       (res),
    .o_res_id    (res_id),
    .i_res_ready (res_ready),
    .o_busy      (busy)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int k, input logic [15:0] a, input logic [15:0] b);
    req_a[k*16 +: 16] = a;
    req_b[k*16 +: 16] = b;
  endtask

  // Advance one cycle; inputs change and outputs are sampled at negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [15:0] sp_a [5] = '{16'h7C00, 16'h7BFF, 16'h0400, 16'h0001, 16'hC000};
  logic [15:0] sp_b [5] = '{16'h0000, 16'h7BFF, 16'h0400, 16'h3C00, 16'h3E00};
  logic [15:0] sp_p [5] = '{16'h7E00, 16'h7C00, 16'h0000, 16'h0000, 16'hC200};

  initial begin
    rst = 1'b1; req_valid = 4'b0001; req_a = '0; req_b = '0; res_ready = 1'b0;
    set_op(0, 16'h3C00, 16'h4000);
    @(negedge clk);
    step();
    // reset state
    chk("rst_valid", 16'(res_valid), 16'h0);
    chk("rst_res",   res, 16'h0000);
    chk("rst_id",    16'(res_id), 16'h0);
    chk("rst_ready", 16'(req_ready), 16'h0);
    chk("rst_busy",  16'(busy), 16'h1);

    // basic product
    rst = 1'b0; res_ready = 1'b1;
    #1 chk("basic_ready", 16'(req_ready), 16'h0001);
    step();
    chk("basic_valid", 16'(res_valid), 16'h1);
    chk("basic_res",   res, 16'h4000);
    chk("basic_id",    16'(res_id), 16'h0);
    req_valid = '0;
    step();
    chk("basic_drain", 16'(res_valid), 16'h0);

    // round robin, ptr starts at 1 after the grant to requester 0
    for (int k = 0; k < 4; k++) set_op(k, 16'h3E00, 16'h3E00);
    req_valid = 4'hF;
    for (int i = 0; i < 6; i++) begin
      #1 chk("rr_ready", 16'(req_ready), 16'(4'b0001 << ((1 + i) % 4)));
      step();
      chk("rr_res", res, 16'h4080);
      chk("rr_id",  16'(res_id), 16'((1 + i) % 4));
    end
    req_valid = '0;
    step();
    chk("rr_drain", 16'(res_valid), 16'h0);

    // backpressure (ptr = 3)
    set_op(2, 16'h4000, 16'h4200);
    req_valid = 4'b0100; res_ready = 1'b0;
    #1 chk("bp_accept", 16'(req_ready), 16'h0004);
    step();
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp_ready", 16'(req_ready), 16'h0);
      chk("bp_res",   res, 16'h4600);
      chk("bp_id",    16'(res_id), 16'h2);
      chk("bp_valid", 16'(res_valid), 16'h1);
      step();
    end
    req_valid = '0; res_ready = 1'b1;
    step();
    chk("bp_drain", 16'(res_valid), 16'h0);

    // simultaneous drain and accept (ptr = 3)
    set_op(1, 16'h3C00, 16'h4000);
    req_valid = 4'b0010; res_ready = 1'b0;
    #1 chk("sim_first", 16'(req_ready), 16'h0002);
    step();
    chk("sim_pend", res, 16'h4000);
    set_op(1, 16'h4000, 16'h4200);
    res_ready = 1'b1;
    #1 chk("sim_ready", 16'(req_ready), 16'h0002);
    step();
    chk("sim_valid", 16'(res_valid), 16'h1);
    chk("sim_res",   res, 16'h4600);
    chk("sim_id",    16'(res_id), 16'h1);
    req_valid = '0;
    step();

    // reset mid-operation (ptr = 2)
    set_op(0, 16'h4000, 16'h4000);
    req_valid = 4'b0001; res_ready = 1'b0;
    step();
    chk("mid_pend", res, 16'h4400);
    rst = 1'b1; req_valid = 4'b1001;
    set_op(0, 16'h3C00, 16'h3C00);
    set_op(3, 16'h4000, 16'h4000);
    #1 chk("mid_rst_ready", 16'(req_ready), 16'h0);
    step();
    chk("mid_valid", 16'(res_valid), 16'h0);
    chk("mid_res",   res, 16'h0000);
    rst = 1'b0; res_ready = 1'b1;
    #1 chk("mid_ptr0", 16'(req_ready), 16'h0001);
    step();
    chk("mid_res0", res, 16'h3C00);
    chk("mid_id0",  16'(res_id), 16'h0);
    #1 chk("mid_next", 16'(req_ready), 16'h0008);
    step();
    chk("mid_res3", res, 16'h4400);
    chk("mid_id3",  16'(res_id), 16'h3);
    req_valid = '0;
    step();

    // special values through requester 1
    for (int i = 0; i < 5; i++) begin
      set_op(1, sp_a[i], sp_b[i]);
      req_valid = 4'b0010;
      #1 chk("sp_ready", 16'(req_ready), 16'h0002);
      step();
      chk("sp_res", res, sp_p[i]);
      chk("sp_id",  16'(res_id), 16'h1);
    end
    req_valid = '0;
    step();
    chk("idle_valid", 16'(res_valid), 16'h0);
    chk("idle_busy",  16'(busy), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
